// File: rtl/gtech_oa21_skid_stage.sv
// -----------------------------------------------------------------------------
// gtech_oa21_skid_stage
//
// Registered consumer stage for OA21 results. Each accepted transaction
// produces Z = (A | B) & C, computed bitwise across W lanes. Results are held
// in a two-entry skid buffer (main + skid register) behind a valid/ready
// handshake. Every output comes straight from a flop, so downstream
// backpressure (OUT_READY) never reaches IN_READY through combinational logic.
//
// Ports
//   CP         in   1  clock, rising edge
//   CD         in   1  asynchronous active-low clear
//   IN_VALID   in   1  upstream transaction valid
//   IN_READY   out  1  stage can accept a transaction this cycle (registered)
//   A, B, C    in   W  OA21 operands, sampled only on an accepted transfer
//   OUT_VALID  out  1  Z holds a valid result (registered)
//   OUT_READY  in   1  downstream accepts Z this cycle
//   Z          out  W  oldest held result, driven from the main register only
//   COUNT      out  2  occupancy, 0..2 (registered)
// -----------------------------------------------------------------------------
module gtech_oa21_skid_stage #(
    parameter int W = 8
) (
    input  logic         CP,
    input  logic         CD,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [W-1:0] C,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [W-1:0] Z,
    output logic [1:0]   COUNT
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t         state;
    logic [W-1:0]   skid;
    logic [W-1:0]   f;
    logic           in_fire;
    logic           out_fire;

    assign f        = (A | B) & C;
    assign in_fire  = IN_VALID & IN_READY;
    assign out_fire = OUT_VALID & OUT_READY;

    // IN_READY, OUT_VALID and COUNT are registered copies of the state
    // decode, updated alongside every transition so they never depend on
    // the current cycle's OUT_READY.
    always_ff @(posedge CP or negedge CD) begin
        if (!CD) begin
            // NOTE: the skid register is cleared too, so no stale data can
            // ever surface after a mid-transfer reset.
            state     <= EMPTY;
            Z         <= '0;
            skid      <= '0;
            IN_READY  <= 1'b1;
            OUT_VALID <= 1'b0;
            COUNT     <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // samples pre-edge values and the update order is irrelevant.
            unique case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state     <= ONE;
                        Z         <= f;
                        OUT_VALID <= 1'b1;
                        COUNT     <= 2'd1;
                    end
                end

                ONE: begin
                    if (in_fire && out_fire) begin
                        // Drain and refill in the same cycle: occupancy holds.
                        Z <= f;
                    end else if (in_fire) begin
                        // Head still blocked; park the newcomer behind it.
                        state    <= FULL;
                        skid     <= f;
                        IN_READY <= 1'b0;
                        COUNT    <= 2'd2;
                    end else if (out_fire) begin
                        // Z is left stale; OUT_VALID low marks it invalid.
                        state     <= EMPTY;
                        OUT_VALID <= 1'b0;
                        COUNT     <= 2'd0;
                    end
                end

                FULL: begin
                    // IN_READY is low here, so in_fire cannot occur.
                    if (out_fire) begin
                        state    <= ONE;
                        Z        <= skid;
                        IN_READY <= 1'b1;
                        COUNT    <= 2'd1;
                    end
                end

                default: begin
                    state     <= EMPTY;
                    IN_READY  <= 1'b1;
                    OUT_VALID <= 1'b0;
                    COUNT     <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gtech_oa21_skid_stage.sv
// -----------------------------------------------------------------------------
// Testbench for gtech_oa21_skid_stage (W = 8).
// A directed vector table covers single transfer, backpressure and
// simultaneous drain/refill; hand-written sequences cover reset, streaming and
// asynchronous clear while full; a long random run is compared against a
// queue-based two-deep FIFO model.
// -----------------------------------------------------------------------------
module tb_gtech_oa21_skid_stage;

    localparam int W = 8;

    logic         CP = 1'b0;
    logic         CD = 1'b0;
    logic         IN_VALID = 1'b0;
    logic         OUT_READY = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [W-1:0] C = '0;
    logic         IN_READY;
    logic         OUT_VALID;
    logic [W-1:0] Z;
    logic [1:0]   COUNT;

    int errors = 0;
    int checks = 0;

    // Reference model: a FIFO holding at most two results, plus the last
    // value seen at the head (Z stays stale after the buffer drains).
    logic [W-1:0] q[$];
    logic [W-1:0] z_exp = '0;

    gtech_oa21_skid_stage #(.W(W)) dut (
        .CP        (CP),
        .CD        (CD),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .C         (C),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .Z         (Z),
        .COUNT     (COUNT)
    );

    always #5 CP = ~CP;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " out_valid"}, {31'd0, OUT_VALID}, {31'd0, q.size() > 0});
        check({tag, " z"},         {24'd0, Z},         {24'd0, z_exp});
        check({tag, " in_ready"},  {31'd0, IN_READY},  {31'd0, q.size() < 2});
        check({tag, " count"},     {30'd0, COUNT},     q.size());
    endtask

    // Drive one cycle's inputs (called at posedge+1), advance the model at
    // the next rising edge and return at posedge+1.
    task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic ordy);
        logic         in_f;
        logic         out_f;
        logic         hold;
        logic [W-1:0] z_before;
        IN_VALID  = v;
        A         = a;
        B         = b;
        C         = c;
        OUT_READY = ordy;
        in_f      = v && (q.size() < 2);
        out_f     = ordy && (q.size() > 0);
        hold      = OUT_VALID && !ordy;
        z_before  = Z;
        @(posedge CP);
        if (out_f) void'(q.pop_front());
        if (in_f)  q.push_back((a | b) & c);
        if (q.size() > 0) z_exp = q[0];
        #1;
        if (hold) check("z_stable_while_stalled", {24'd0, Z}, {24'd0, z_before});
    endtask

    typedef struct {
        logic       v;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic       ordy;
        logic       ov;
        logic [7:0] z;
        logic       ir;
        logic [1:0] cnt;
    } vec_t;

    vec_t tbl[10];

    initial begin
        // Expected outputs after the rising edge that consumes each row.
        tbl[0] = '{1'b1, 8'hF0, 8'h0F, 8'hAA, 1'b1, 1'b1, 8'hAA, 1'b1, 2'd1}; // single transfer
        tbl[1] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'hAA, 1'b1, 2'd0}; // drained, Z stale
        tbl[2] = '{1'b1, 8'h01, 8'h02, 8'h03, 1'b0, 1'b1, 8'h03, 1'b1, 2'd1}; // T0 under backpressure
        tbl[3] = '{1'b1, 8'h10, 8'h20, 8'hFF, 1'b0, 1'b1, 8'h03, 1'b0, 2'd2}; // T1 into skid
        tbl[4] = '{1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1, 8'h03, 1'b0, 2'd2}; // full: not accepted
        tbl[5] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h30, 1'b1, 2'd1}; // T0 out, skid to main
        tbl[6] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h30, 1'b1, 2'd0}; // T1 out
        tbl[7] = '{1'b1, 8'h55, 8'h00, 8'hFF, 1'b0, 1'b1, 8'h55, 1'b1, 2'd1}; // load one
        tbl[8] = '{1'b1, 8'h00, 8'h0C, 8'h0F, 1'b1, 1'b1, 8'h0C, 1'b1, 2'd1}; // in+out fire in ONE
        tbl[9] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h0C, 1'b1, 2'd0}; // drained

        // ---- reset held with random inputs, released away from the edge ----
        CD = 1'b0;
        repeat (3) begin
            @(posedge CP);
            IN_VALID  = 1'($urandom);
            OUT_READY = 1'($urandom);
            A = W'($urandom); B = W'($urandom); C = W'($urandom);
        end
        IN_VALID = 1'b0;
        @(negedge CP);
        CD = 1'b1;
        #1;
        check_model("reset");
        @(posedge CP);
        #1;
        check_model("post_reset_no_pulse");

        // ---- directed table ----
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].ordy);
            check($sformatf("tbl%0d out_valid", i), {31'd0, OUT_VALID}, {31'd0, tbl[i].ov});
            check($sformatf("tbl%0d z", i),         {24'd0, Z},         {24'd0, tbl[i].z});
            check($sformatf("tbl%0d in_ready", i),  {31'd0, IN_READY},  {31'd0, tbl[i].ir});
            check($sformatf("tbl%0d count", i),     {30'd0, COUNT},     {30'd0, tbl[i].cnt});
            check_model($sformatf("tbl%0d model", i));
        end

        // ---- streaming: Z follows 1..16 on consecutive cycles ----
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b1, W'(i), 8'h00, 8'hFF, 1'b1);
            check($sformatf("stream%0d z", i), {24'd0, Z}, i);
            check($sformatf("stream%0d in_ready", i), {31'd0, IN_READY}, 32'd1);
            check($sformatf("stream%0d out_valid", i), {31'd0, OUT_VALID}, 32'd1);
        end
        cycle(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        check_model("stream_drain");

        // ---- asynchronous clear mid-cycle while FULL ----
        cycle(1'b1, 8'h81, 8'h00, 8'hFF, 1'b0);
        cycle(1'b1, 8'h42, 8'h00, 8'hFF, 1'b0);
        check_model("fill_full");
        check("full count", {30'd0, COUNT}, 32'd2);
        #2;
        CD = 1'b0;
        #1;
        check("async_clr out_valid", {31'd0, OUT_VALID}, 32'd0);
        check("async_clr z",         {24'd0, Z},         32'd0);
        check("async_clr in_ready",  {31'd0, IN_READY},  32'd1);
        check("async_clr count",     {30'd0, COUNT},     32'd0);
        q.delete();
        z_exp = '0;
        IN_VALID  = 1'b1;
        OUT_READY = 1'b1;
        repeat (2) @(posedge CP);
        IN_VALID = 1'b0;
        #2;
        CD = 1'b1;
        @(posedge CP);
        #1;
        check_model("after_async_clr");

        // ---- random traffic against the FIFO model ----
        for (int n = 0; n < 10000; n++) begin
            cycle($urandom_range(0, 9) < 7, W'($urandom), W'($urandom), W'($urandom),
                  $urandom_range(0, 9) < 5);
            check_model("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
